// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: IMEM request/response, MEM redirect and ID handshake signals of ifetch_queue.
// master = fetch front end, slave = environment (IMEM, MEM stage, ID stage).
interface ifetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_inst;
    logic [XLEN-1:0]  id_pc;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid, id_inst, id_pc, occupancy,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid, id_inst, id_pc, occupancy,
        output id_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch-PC generator, credit-limited IMEM requester and DEPTH-entry in-order queue to ID.
// Define IFQ_BYPASS_EN to forward a response to ID in the same cycle when the queue is empty.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [XLEN-1:0]  fetch_pc_reg, resp_pc_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] discard_reg, discard_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [31:0]      inst_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem [DEPTH];

    logic             redirect;
    logic [CNT_W:0]   inflight;
    logic             credit_ok;
    logic             req;
    logic             grant;
    logic             rsp;
    logic             accept;
    logic             push;
    logic             pop;
    logic             q_nonempty;
    logic             bypass_hit;
    logic             bypass_take;

    assign redirect   = bus.redirect_valid;
    assign q_nonempty = (count_reg != '0);
    // Credit counts queued plus in-flight words so every response always has a free slot.
    assign inflight   = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign credit_ok  = (inflight < DEPTH_W);
    assign grant      = req && bus.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp        = bus.imem_rvalid && (outstanding_reg != '0);
    assign accept     = rsp && (discard_reg == '0) && !redirect;

`ifdef IFQ_BYPASS_EN
    assign bypass_hit  = accept && !q_nonempty;
    assign bypass_take = bypass_hit && bus.id_ready;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push = accept && !bypass_take;
    assign pop  = q_nonempty && bus.id_ready && !redirect;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (grant && !rsp)
            outstanding_next = outstanding_reg + CNT_W'(1);
        else if (rsp && !grant)
            outstanding_next = outstanding_reg - CNT_W'(1);
    end

    // A redirect drops everything still in flight, including a word returning this cycle.
    always_comb begin
        discard_next = discard_reg;
        if (redirect)
            discard_next = outstanding_next;
        else if (rsp && (discard_reg != '0))
            discard_next = discard_reg - CNT_W'(1);
    end

    always_comb begin
        count_next = count_reg;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + CNT_W'(1);
        else if (pop && !push)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= BOOT;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:  state_next = FETCH;
            FETCH: if (redirect && (outstanding_next != '0)) state_next = DRAIN;
            DRAIN: if (discard_next == '0) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        req           = (state_reg != BOOT) && !redirect && credit_ok;
        bus.imem_req  = req;
        bus.imem_addr = fetch_pc_reg;
        bus.occupancy = count_reg;
        bus.id_valid  = q_nonempty || bypass_hit;
        bus.id_inst   = NOP;
        bus.id_pc     = '0;
        if (q_nonempty) begin
            bus.id_inst = inst_mem[rd_ptr_reg];
            bus.id_pc   = pc_mem[rd_ptr_reg];
        end else if (bypass_hit) begin
            bus.id_inst = bus.imem_rdata;
            bus.id_pc   = resp_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect) begin
                fetch_pc_reg <= bus.redirect_pc;
                resp_pc_reg  <= bus.redirect_pc;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
            end else begin
                if (grant)  fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                if (accept) resp_pc_reg  <= resp_pc_reg + XLEN'(4);
                if (push)   wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                if (pop)    rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage carries no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= bus.imem_rdata;
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
        end
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined core.
- Replaces the single-slot IF path (PC register, next-PC logic, one IF/ID register) with a fetch-PC generator, a credit-limited multi-request IMEM interface and a DEPTH-entry in-order instruction queue feeding ID through a valid/ready handshake.
- Branch/jump redirects from MEM flush the queue and drop in-flight responses.

Parameters:
XLEN, 32, width of PC and addresses
DEPTH, 4, queue entries; power of 2, >=2; also the max of (queued + outstanding)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address; word-aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid; responses return in request order
imem_rdata  input  32  instruction word
redirect_valid  input  1  taken branch/jump from MEM stage
redirect_pc  input  XLEN  redirect target
id_valid  output  1  instruction available to ID
id_ready  input  1  ID accepts; low = stall
id_inst  output  32  instruction word
id_pc  output  XLEN  PC of id_inst
occupancy  output  $clog2(DEPTH+1)  queued entries

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: state=BOOT, fetch_pc=RESET_PC, count=0, outstanding=0, discard=0. Outputs: imem_req=0, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, occupancy=0.
- FSM states:
  - BOOT: one cycle, no request, then FETCH.
  - FETCH: discard==0.
  - DRAIN: discard>0. Enter on a redirect if the post-cycle outstanding count is >0. Return to FETCH when discard reaches 0.
- Credit: imem_req = (state!=BOOT) && !redirect_valid && (count + outstanding < DEPTH). The credit uses registered values, so a pop this cycle does not free credit until the next cycle.
- Request hold: imem_addr=fetch_pc while imem_req is high. On imem_req&&imem_gnt: fetch_pc += 4 (wraps mod 2^XLEN) and outstanding += 1.
- Responses: on imem_rvalid, outstanding -= 1.
  - If discard>0: the word is dropped and discard -= 1.
  - Otherwise: push {rdata, pc}. Queue pc is tracked by a separate resp_pc register that increments by 4 per accepted response and is loaded on redirect.
- Grant and response in the same cycle: outstanding is unchanged.
- Pop on id_valid&&id_ready. id_valid=(count>0). id_inst/id_pc come from the head entry. When empty: id_inst=NOP, id_pc=0.
- Push and pop in the same cycle: count is unchanged. The queue can never overflow, because credit guarantees it. imem_rvalid with outstanding==0 is a protocol error; the word is ignored.
- Redirect (priority over push, pop and grant):
  - count <= 0 and queue pointers are reset.
  - fetch_pc <= redirect_pc and resp_pc <= redirect_pc.
  - discard <= outstanding_next, which includes any response arriving this cycle (that word is also dropped).
  - id_ready is ignored this cycle; no pop.
- Redirect while in DRAIN: discard is recomputed the same way (discard <= outstanding_next).
- Reset mid-operation: everything returns to reset values. Responses still in flight in the IMEM after reset are the IMEM's responsibility; the IMEM shares the same reset.
- Latency: grant-to-rvalid >= 1 cycle. rvalid to id_valid is 1 cycle (registered queue).

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0, discard==0, imem_rvalid=1 and no redirect, id_valid=1 in the same cycle, with id_inst=imem_rdata and id_pc=resp_pc.
  - If id_ready=1, the word is consumed and not pushed.
  - If id_ready=0, the word is pushed normally.
- Undefined: rvalid-to-id_valid is always 1 cycle. There is no combinational path from imem_rdata to id_inst.

Test Plan:
- Reset then IMEM always granting with 1-cycle rvalid, id_ready=1 → imem_addr sequence 0x0,0x4,0x8,…; id_pc sequence matches; id_valid first high 3 cycles after reset release (2 with IFQ_BYPASS_EN).
- id_ready=0 for 10 cycles, DEPTH=4 → occupancy saturates at 4, imem_req=0, outstanding=0, no data lost; on release, 4 consecutive pops with PCs 0x0..0xC.
- IMEM rvalid latency 3, two requests outstanding, redirect_pc=0x100 → queue empties the next cycle; both stale words dropped (state=DRAIN for 2 responses); first id_pc after redirect is 0x100.
- Redirect in the same cycle as rvalid and id_ready=1 → no pop and no push that cycle; occupancy=0; the following fetch uses addr 0x100.
- Second redirect (0x200) while in DRAIN with discard=1 and one new request in flight → discard=2; next delivered id_pc=0x200.
- fetch_pc=32'hFFFF_FFFC granted → next imem_addr=0x0000_0000 (wrap).
